// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared types and board constants for the connect-four datapath
// Purpose: cell/player colour encoding, move controller states, default board size,
//          and a turn-toggle helper.
// Ports: none (package).
package connect4_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10
  } light_t;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    PLACE,
    CHECK,
    OVER
  } ctrl_state_t;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 7;

  function automatic light_t next_player(input light_t p);
    return (p == GREEN) ? RED : GREEN;
  endfunction

endpackage

// File: rtl/drop_controller_rise_edge.sv
// rtl/drop_controller_rise_edge.sv - rising-edge detector for synchronised button levels
// Purpose: one-cycle pulse on each 0->1 transition of a level input.
// Ports:
//   clock - system clock, posedge
//   reset - asynchronous, active-low
//   level - synchronised button level
//   pulse - high for one cycle after level rises
module rise_edge (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/drop_controller.sv
// rtl/drop_controller.sv - connect-four move controller driving the cell array
// Purpose: turns a column select plus drop press into a one-hot cell load for the
//          lowest empty row, waits for the win detector, alternates turns, and
//          tracks column-full, draw and game-over. Issues the board clear on new game.
// Ports:
//   clock      - system clock, posedge
//   reset      - asynchronous, active-low
//   drop       - drop request level (edge-detected internally)
//   col_sel    - selected column, 0 = leftmost
//   new_game   - level; forces a board clear
//   win        - win detector output for the current board
//   player     - colour to place (2'b10 green, 2'b01 red)
//   cell_load  - one-hot load, bit = row*COLS + col, row 0 = bottom
//   cell_clear - one-cycle pulse clearing every cell
//   col_full   - bit c set when column c is full
//   busy       - controller not in IDLE or OVER
//   game_over  - controller in OVER
//   draw       - board filled without a win
module drop_controller
  import connect4_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int CW   = $clog2(COLS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 drop,
  input  logic [CW-1:0]        col_sel,
  input  logic                 new_game,
  input  logic                 win,
  output logic [1:0]           player,
  output logic [ROWS*COLS-1:0] cell_load,
  output logic                 cell_clear,
  output logic [COLS-1:0]      col_full,
  output logic                 busy,
  output logic                 game_over,
  output logic                 draw
);

  localparam int HW = $clog2(ROWS + 1);
  localparam int MW = $clog2(ROWS * COLS + 1);
  localparam int IW = $clog2(ROWS * COLS);

  ctrl_state_t   state, next_state;
  logic [HW-1:0] h [COLS];
  logic [MW-1:0] moves;
  logic [CW-1:0] col_q;
  light_t        player_q;
  logic          drop_edge;
  logic          col_ok;
  logic          board_full;
  logic [IW-1:0] load_idx;

  rise_edge u_drop_edge (
    .clock (clock),
    .reset (reset),
    .level (drop),
    .pulse (drop_edge)
  );

  always_comb begin
    col_full = '0;
    for (int c = 0; c < COLS; c++) col_full[c] = (h[c] == HW'(ROWS));
  end

  // Out-of-range columns are rejected before col_full is consulted.
  assign col_ok     = (int'(col_sel) < COLS) && !col_full[col_sel] && !win;
  assign board_full = (moves == MW'(ROWS * COLS));
  assign load_idx   = IW'(h[col_q]) * IW'(COLS) + IW'(col_q);

  always_comb begin
    next_state = state;
    case (state)
      CLEAR: next_state = IDLE;
      IDLE:  if (drop_edge && col_ok) next_state = PLACE;
      PLACE: next_state = CHECK;
      CHECK: begin
        if (win || board_full) next_state = OVER;
        else                   next_state = IDLE;
      end
      OVER:    next_state = OVER;
      default: next_state = CLEAR;
    endcase
    if (new_game) next_state = CLEAR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      moves      <= '0;
      col_q      <= '0;
      player_q   <= GREEN;
      draw       <= 1'b0;
      cell_clear <= 1'b0;
      for (int c = 0; c < COLS; c++) h[c] <= '0;
    end else begin
      state <= next_state;
      // Registered so it never coincides with a PLACE-cycle load.
      cell_clear <= (state == CLEAR);
      case (state)
        CLEAR: begin
          moves    <= '0;
          player_q <= GREEN;
          draw     <= 1'b0;
          for (int c = 0; c < COLS; c++) h[c] <= '0;
        end
        IDLE: if (next_state == PLACE) col_q <= col_sel;
        PLACE: begin
          h[col_q] <= h[col_q] + 1'b1;
          moves    <= moves + 1'b1;
        end
        CHECK: begin
          if (next_state == IDLE) player_q <= next_player(player_q);
          if (next_state == OVER && !win) draw <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Decoded from state so an async reset in PLACE kills the load at once.
  always_comb begin
    cell_load = '0;
    if (state == PLACE) cell_load[load_idx] = 1'b1;
  end

  assign player    = player_q;
  assign busy      = (state != IDLE) && (state != OVER);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_drop_controller.sv
// tb/tb_drop_controller.sv - self-checking bench for drop_controller
module tb_drop_controller;

  localparam int COLS = 7;
  localparam int ROWS = 6;
  localparam logic [1:0] P_GREEN = 2'b10;
  localparam logic [1:0] P_RED   = 2'b01;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 drop = 1'b0;
  logic [2:0]           col_sel = '0;
  logic                 new_game = 1'b0;
  logic                 win = 1'b0;
  logic [1:0]           player;
  logic [ROWS*COLS-1:0] cell_load;
  logic                 cell_clear;
  logic [COLS-1:0]      col_full;
  logic                 busy;
  logic                 game_over;
  logic                 draw;

  int tests = 0;
  int fails = 0;
  int n_loads = 0;
  int n_clears = 0;
  int exp_q[$];

  int         hm [COLS];
  int         m_moves;
  logic [1:0] m_player;
  bit         m_over;

  drop_controller #(.COLS(COLS), .ROWS(ROWS), .CW(3)) dut (
    .clock(clock), .reset(reset), .drop(drop), .col_sel(col_sel),
    .new_game(new_game), .win(win), .player(player), .cell_load(cell_load),
    .cell_clear(cell_clear), .col_full(col_full), .busy(busy),
    .game_over(game_over), .draw(draw)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every observed load must match the next queued index.
  always @(negedge clock) begin
    logic [ROWS*COLS-1:0] one;
    int e;
    if (cell_clear === 1'b1) n_clears++;
    if (cell_load !== '0) begin
      n_loads++;
      tests++;
      if ($countones(cell_load) != 1 || cell_clear !== 1'b0) begin
        fails++;
        $display("FAIL load_onehot: cell_load=%h cell_clear=%b, required one bit and no clear", cell_load, cell_clear);
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_load: cell_load=%h, required none", cell_load);
      end else begin
        e = exp_q.pop_front();
        one = 1;
        one = one << e;
        if (cell_load !== one) begin
          fails++;
          $display("FAIL load_index: cell_load=%h, required bit %0d", cell_load, e);
        end
      end
    end
  end

  task automatic model_clear();
    for (int c = 0; c < COLS; c++) hm[c] = 0;
    m_moves = 0;
    m_player = P_GREEN;
    m_over = 0;
  endtask

  // Press drop on column c for hold cycles, then release; model updates turn state.
  task automatic do_drop(input int c, input int hold);
    bit acc;
    acc = !m_over && c < COLS && hm[(c < COLS) ? c : 0] < ROWS;
    @(negedge clock);
    col_sel = c[2:0];
    drop = 1'b1;
    if (acc) begin
      exp_q.push_back(hm[c] * COLS + c);
      hm[c]++;
      m_moves++;
      if (m_moves == ROWS * COLS) m_over = 1;
      else m_player = (m_player == P_GREEN) ? P_RED : P_GREEN;
    end
    repeat (hold) @(negedge clock);
    drop = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_new_game();
    @(negedge clock);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    repeat (3) @(negedge clock);
    model_clear();
  endtask

  task automatic test_reset();
    int c0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests++; if (cell_load !== '0) begin fails++; $display("FAIL reset_load: got %h, required 0", cell_load); end
    tests++; if (cell_clear !== 1'b0) begin fails++; $display("FAIL reset_clear: got %b, required 0", cell_clear); end
    tests++; if (player !== P_GREEN) begin fails++; $display("FAIL reset_player: got %b, required 10", player); end
    tests++; if (busy !== 1'b1 || game_over !== 1'b0 || draw !== 1'b0) begin fails++; $display("FAIL reset_flags: busy=%b over=%b draw=%b, required 1 0 0", busy, game_over, draw); end
    c0 = n_clears;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    tests++; if (n_clears - c0 != 1) begin fails++; $display("FAIL reset_clear_pulse: got %0d cycles, required 1", n_clears - c0); end
    tests++; if (col_full !== '0 || busy !== 1'b0 || player !== P_GREEN) begin fails++; $display("FAIL post_clear: col_full=%b busy=%b player=%b, required 0 0 10", col_full, busy, player); end
    model_clear();
  endtask

  task automatic test_basic();
    int l0;
    l0 = n_loads;
    do_drop(3, 10);
    tests++; if (n_loads - l0 != 1) begin fails++; $display("FAIL held_drop_loads: got %0d, required 1", n_loads - l0); end
    tests++; if (player !== P_RED) begin fails++; $display("FAIL turn_toggle1: got %b, required 01", player); end
    do_drop(3, 4);
    tests++; if (player !== P_GREEN) begin fails++; $display("FAIL turn_toggle2: got %b, required 10", player); end
  endtask

  task automatic test_col_full();
    int l0;
    for (int i = 0; i < ROWS; i++) do_drop(0, 4);
    tests++; if (col_full[0] !== 1'b1) begin fails++; $display("FAIL col_full0: got %b, required 1", col_full[0]); end
    l0 = n_loads;
    do_drop(0, 4);
    tests++; if (n_loads != l0 || player !== m_player || busy !== 1'b0) begin fails++; $display("FAIL full_col_drop: loads+%0d player=%b busy=%b, required +0 %b 0", n_loads - l0, player, busy, m_player); end
  endtask

  task automatic test_edge_cases();
    int l0;
    l0 = n_loads;
    do_drop(7, 4);
    tests++; if (n_loads != l0 || player !== m_player || busy !== 1'b0) begin fails++; $display("FAIL col7_ignored: loads+%0d player=%b busy=%b, required +0 %b 0", n_loads - l0, player, busy, m_player); end
    // press, release, then re-press while the controller sits in CHECK
    l0 = n_loads;
    @(negedge clock);
    col_sel = 3'd1; drop = 1'b1;
    exp_q.push_back(hm[1] * COLS + 1); hm[1]++; m_moves++;
    m_player = (m_player == P_GREEN) ? P_RED : P_GREEN;
    @(negedge clock); drop = 1'b0;
    @(negedge clock); drop = 1'b1;
    repeat (6) @(negedge clock);
    drop = 1'b0;
    @(negedge clock);
    tests++; if (n_loads - l0 != 1 || player !== m_player) begin fails++; $display("FAIL check_repress: loads+%0d player=%b, required +1 %b", n_loads - l0, player, m_player); end
  endtask

  task automatic test_win();
    int l0, c0;
    @(negedge clock);
    col_sel = 3'd2; drop = 1'b1;
    exp_q.push_back(hm[2] * COLS + 2); hm[2]++; m_moves++;
    @(negedge clock);
    @(negedge clock); win = 1'b1;
    @(negedge clock); win = 1'b0; drop = 1'b0;
    @(negedge clock);
    tests++; if (game_over !== 1'b1 || draw !== 1'b0 || player !== m_player) begin fails++; $display("FAIL win_over: over=%b draw=%b player=%b, required 1 0 %b", game_over, draw, player, m_player); end
    l0 = n_loads;
    @(negedge clock); col_sel = 3'd4; drop = 1'b1;
    repeat (4) @(negedge clock); drop = 1'b0;
    @(negedge clock);
    tests++; if (n_loads != l0 || game_over !== 1'b1) begin fails++; $display("FAIL over_ignores_drop: loads+%0d over=%b, required +0 1", n_loads - l0, game_over); end
    c0 = n_clears;
    pulse_new_game();
    tests++; if (n_clears - c0 != 1 || busy !== 1'b0 || game_over !== 1'b0 || player !== P_GREEN) begin fails++; $display("FAIL new_game: clears=%0d busy=%b over=%b player=%b, required 1 0 0 10", n_clears - c0, busy, game_over, player); end
  endtask

  task automatic test_newgame_vs_drop();
    int l0;
    do_drop(5, 4);
    l0 = n_loads;
    @(negedge clock);
    col_sel = 3'd6; drop = 1'b1; new_game = 1'b1;
    @(negedge clock); new_game = 1'b0;
    repeat (4) @(negedge clock); drop = 1'b0;
    @(negedge clock);
    model_clear();
    tests++; if (n_loads != l0 || player !== P_GREEN || col_full !== '0 || busy !== 1'b0) begin fails++; $display("FAIL newgame_beats_drop: loads+%0d player=%b col_full=%b busy=%b, required +0 10 0 0", n_loads - l0, player, col_full, busy); end
  endtask

  task automatic test_draw();
    int l0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) do_drop(c, 4);
    tests++; if (game_over !== 1'b1 || draw !== 1'b1 || col_full !== 7'h7f) begin fails++; $display("FAIL draw_state: over=%b draw=%b col_full=%h, required 1 1 7f", game_over, draw, col_full); end
    tests++; if (player !== P_RED) begin fails++; $display("FAIL draw_player: got %b, required 01", player); end
    l0 = n_loads;
    do_drop(3, 4);
    tests++; if (n_loads != l0) begin fails++; $display("FAIL draw_ignores_drop: loads+%0d, required +0", n_loads - l0); end
    pulse_new_game();
  endtask

  task automatic test_reset_mid_place();
    @(negedge clock);
    col_sel = 3'd4; drop = 1'b1;
    exp_q.push_back(4);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    tests++; if (cell_load !== '0) begin fails++; $display("FAIL reset_in_place: cell_load=%h, required 0", cell_load); end
    drop = 1'b0;
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    model_clear();
    tests++; if (col_full !== '0 || player !== P_GREEN) begin fails++; $display("FAIL after_reset: col_full=%b player=%b, required 0 10", col_full, player); end
    do_drop(4, 4);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_col_full();
    test_edge_cases();
    test_win();
    test_newgame_vs_drop();
    test_draw();
    test_reset_mid_place();
    repeat (2) @(negedge clock);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_loads: %0d expected loads never seen, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/drop_controller.md
Name: drop_controller

Overview:
Move controller directly upstream of the board's cell array. Takes the player's column select and drop button, finds the lowest empty row in that column, and fires a one-cycle load strobe to exactly one cell together with the current player colour. It then waits a cycle for the win detector, alternates turns, and tracks column-full, draw and game-over. It also issues the board-wide clear on new game.

Parameters:
COLS, 7, number of board columns
ROWS, 6, number of board rows
CW, $clog2(COLS), column-select width

Ports:
clock  in  1  system clock, posedge
reset  in  1  asynchronous, active-low; 0 = reset asserted
drop  in  1  drop request, level, already synchronised; acted on at rising edge only
col_sel  in  CW  selected column, 0 = leftmost
new_game  in  1  level; starts a fresh game
win  in  1  from win detector, combinational on current cell lights
player  out  2  colour to place: 2'b10 green, 2'b01 red; drives cells' colour input
cell_load  out  ROWS*COLS  one-hot load pulse; bit index = row*COLS + col, row 0 = bottom
cell_clear  out  1  one-cycle pulse clearing every cell to off
col_full  out  COLS  bit c = 1 when column c holds ROWS pieces
busy  out  1  1 in any state other than IDLE and OVER
game_over  out  1  1 in OVER
draw  out  1  1 in OVER when the board filled with win=0

Behaviour:
- Reset (reset=0, async):
  - state=CLEAR, all heights=0, moves=0, player=2'b10.
  - cell_load=0, draw=0, drop edge register=0.
  - cell_clear is registered and asserts on the first clock after reset release.
- Drop edge detect: drop_q <= drop every cycle; edge = drop & ~drop_q. A held drop produces exactly one edge.
- Per-column height counter h[c], width $clog2(ROWS+1). col_full[c] = (h[c]==ROWS).
- Total move counter, width $clog2(ROWS*COLS+1).
- States:
  - CLEAR: cell_clear=1 for exactly this one cycle; h[*]=0, moves=0, player=green, draw=0 -> IDLE.
  - IDLE: on edge with col_sel<COLS, ~col_full[col_sel] and win=0, latch col -> PLACE. Any other edge is ignored, with no state change.
  - PLACE: cell_load[h[col]*COLS+col]=1 for exactly this cycle; h[col]++, moves++ -> CHECK.
  - CHECK: cells have latched; win now reflects the new board.
    - win=1 -> OVER, player unchanged (player shows the winner).
    - else if moves==ROWS*COLS -> OVER, draw=1.
    - else toggle player (10<->01) -> IDLE.
  - OVER: all drop edges ignored; wait for new_game.
- new_game=1 in any state forces CLEAR on the next edge and overrides drop. While held, state stays in CLEAR and cell_clear stays high.
- Drop latency: the edge sampled at clock n gives cell_load at cycle n+1 and player toggles at n+3. The next drop is accepted from n+3.
- Drop edges arriving during PLACE/CHECK are discarded, not queued.
- cell_load and cell_clear are never asserted in the same cycle.
- At most one cell_load bit is set in any cycle.
- Reset asserted mid-PLACE: cell_load drops to 0 immediately (async).

Decomposition:
- Package connect4_pkg:
  - light_t enum {OFF=2'b00, RED=2'b01, GREEN=2'b10}; player and the cell state use this type.
  - ctrl_state_t enum {CLEAR, IDLE, PLACE, CHECK, OVER}.
  - Default ROWS/COLS constants.
- Sub-module rise_edge: one flop plus AND, with clock and reset (active-low async). Reused later for the column-select buttons.

Test Plan:
- Reset then release -> cell_clear high for exactly 1 cycle, player=2'b10, col_full=0, busy=0 after CLEAR.
- col_sel=3, drop 0->1 held 10 cycles -> exactly one pulse on cell_load[3]; then player=2'b01. Second drop on col 3 -> cell_load[10] (row 1), player back to 2'b10.
- Fill column 0 with 6 drops -> col_full[0]=1; a 7th drop on col 0 -> no cell_load, player unchanged, state IDLE.
- Force win=1 during CHECK after drop 7 -> game_over=1, draw=0, player held at mover's colour; further drops produce no cell_load. new_game pulse -> cell_clear 1 cycle, then IDLE with player green.
- Draw: 42 drops in a non-winning order with win=0 -> after the 42nd CHECK, game_over=1, draw=1, all col_full=1. Check the bottom-left and top-right index mapping: load bits 0 and 41.
- Edge cases:
  - col_sel=7 -> ignored.
  - Drop re-pressed during CHECK -> discarded.
  - Reset pulled low in PLACE -> cell_load immediately 0, h[*]=0.
  - new_game and a drop edge in the same cycle -> CLEAR wins, no cell_load.
